// File: rtl/jt12_timer_bank_pkg.sv
// jt12_timer_bank_pkg
//   Shared constants and types for the JT12 timer bank.
//   - JT12_TIMER_PRE  : default prescaler period in cen cycles
//   - JT12_TIMER_W    : default counter width
//   - JT12_TIMER_DW   : field width of each div_log2 entry
//   - JT12_TIMER_SUBW : width of the per-timer sub-divider counter
//   - tmr_state_e     : per-timer run state
//   - sub_mask()      : low-bit mask selecting the sub-divider bits that must be all ones
package jt12_timer_bank_pkg;

  localparam int JT12_TIMER_PRE  = 144;
  localparam int JT12_TIMER_W    = 10;
  localparam int JT12_TIMER_DW   = 4;
  localparam int JT12_TIMER_SUBW = 15;

  typedef enum logic {
    TMR_IDLE = 1'b0,
    TMR_RUN  = 1'b1
  } tmr_state_e;

  // Mask of the d low bits; d=0 yields 0, so every prescaler tick is a timer tick.
  function automatic logic [JT12_TIMER_SUBW-1:0] sub_mask(input logic [JT12_TIMER_DW-1:0] d);
    logic [JT12_TIMER_SUBW:0] full;
    full = ((JT12_TIMER_SUBW+1)'(1) << d) - (JT12_TIMER_SUBW+1)'(1);
    return full[JT12_TIMER_SUBW-1:0];
  endfunction

endpackage

// File: rtl/jt12_timer_bank_cnt.sv
// jt12_timer_cnt
//   One timer of the bank: run/idle state, power-of-two sub-divider,
//   up-counter with reload, sticky flag and one-cycle overflow pulse.
//   Ports:
//     clk, rst      : clock, asynchronous active-high reset
//     ptick         : shared prescaler tick (already qualified by cen)
//     value         : reload value
//     div_log2      : sub-divider exponent, timer advances every 2^d pticks
//     set_run       : pulse, start (ignored while running)
//     clr_run       : pulse, stop (wins over set_run)
//     enable_irq    : level, allow overflow to set the flag
//     clr_flag      : pulse, clear flag (loses to a same-cycle set)
//     running       : run state (the FSM state, 1 = TMR_RUN)
//     flag          : sticky overflow flag
//     overflow      : one-cycle overflow pulse
module jt12_timer_cnt
  import jt12_timer_bank_pkg::*;
#(
  parameter int W = JT12_TIMER_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ptick,
  input  logic [W-1:0]             value,
  input  logic [JT12_TIMER_DW-1:0] div_log2,
  input  logic                     set_run,
  input  logic                     clr_run,
  input  logic                     enable_irq,
  input  logic                     clr_flag,
  output logic                     running,
  output logic                     flag,
  output logic                     overflow
);

  tmr_state_e                 state_q, state_d;
  logic [JT12_TIMER_SUBW-1:0] sub_q, sub_d;
  logic [W-1:0]               cnt_q, cnt_d;
  logic                       flag_q, flag_d;
  logic                       ovf_q, ovf_d;
  logic [JT12_TIMER_SUBW-1:0] mask;

  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
    cnt_d   = cnt_q;
    flag_d  = flag_q;
    ovf_d   = 1'b0;
    mask    = sub_mask(div_log2);

    // Clear first so that an overflow in the same cycle re-sets the flag.
    if (clr_flag) flag_d = 1'b0;

    case (state_q)
      TMR_IDLE: begin
        if (set_run && !clr_run) begin
          state_d = TMR_RUN;
          cnt_d   = value;
          sub_d   = '0;
        end
      end
      TMR_RUN: begin
        if (clr_run) begin
          state_d = TMR_IDLE;
        end else if (ptick) begin
          sub_d = sub_q + JT12_TIMER_SUBW'(1);
          if ((sub_q & mask) == mask) begin
            if (cnt_q == '1) begin
              // value is sampled here, so mid-run edits only affect this reload onward.
              cnt_d = value;
              ovf_d = 1'b1;
              if (enable_irq) flag_d = 1'b1;
            end else begin
              cnt_d = cnt_q + W'(1);
            end
          end
        end
      end
      default: state_d = TMR_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= TMR_IDLE;
      sub_q   <= '0;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sub_q   <= sub_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
      ovf_q   <= ovf_d;
    end
  end

  assign running  = (state_q == TMR_RUN);
  assign flag     = flag_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/jt12_timer_bank.sv
// jt12_timer_bank
//   NTIM up-counting timers sharing one prescaler, with per-timer
//   sub-divider, run/flag/IRQ control and a combined active-low interrupt.
//   Ports:
//     clk, rst     : clock, asynchronous active-high reset
//     cen          : clock enable, gates the prescaler (and thus all counting)
//     value        : reload values, timer i at [i*W +: W]
//     div_log2     : sub-divider exponents, timer i at [i*4 +: 4]
//     set_run      : per-timer start pulses
//     clr_run      : per-timer stop pulses
//     enable_irq   : per-timer flag enables
//     clr_flag     : per-timer flag clear pulses
//     running      : per-timer run state
//     flag         : per-timer sticky overflow flags
//     overflow     : per-timer one-cycle overflow pulses
//     irq_n        : low while any flag is set
//   Handshake: there is no valid/ready flow; every control input is a
//   single-cycle pulse (or level for enable_irq) sampled on each clk edge,
//   and all control pulses are honoured even while cen is low.
module jt12_timer_bank
  import jt12_timer_bank_pkg::*;
#(
  parameter int NTIM = 2,
  parameter int W    = JT12_TIMER_W,
  parameter int PRE  = JT12_TIMER_PRE
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cen,
  input  logic [NTIM*W-1:0]             value,
  input  logic [NTIM*JT12_TIMER_DW-1:0] div_log2,
  input  logic [NTIM-1:0]               set_run,
  input  logic [NTIM-1:0]               clr_run,
  input  logic [NTIM-1:0]               enable_irq,
  input  logic [NTIM-1:0]               clr_flag,
  output logic [NTIM-1:0]               running,
  output logic [NTIM-1:0]               flag,
  output logic [NTIM-1:0]               overflow,
  output logic                          irq_n
);

  localparam int PW = (PRE > 1) ? $clog2(PRE) : 1;

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          ptick;

  // With PRE=1 pcnt stays at 0 == PRE-1, so ptick degenerates to cen.
  always_comb begin
    pcnt_d = pcnt_q;
    ptick  = cen && (pcnt_q == PW'(PRE - 1));
    if (cen) begin
      if (ptick) pcnt_d = '0;
      else       pcnt_d = pcnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pcnt_q <= '0;
    else     pcnt_q <= pcnt_d;
  end

  for (genvar i = 0; i < NTIM; i++) begin : g_tmr
    jt12_timer_cnt #(
      .W(W)
    ) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .ptick      (ptick),
      .value      (value[i*W +: W]),
      .div_log2   (div_log2[i*JT12_TIMER_DW +: JT12_TIMER_DW]),
      .set_run    (set_run[i]),
      .clr_run    (clr_run[i]),
      .enable_irq (enable_irq[i]),
      .clr_flag   (clr_flag[i]),
      .running    (running[i]),
      .flag       (flag[i]),
      .overflow   (overflow[i])
    );
  end

  assign irq_n = ~|flag;

endmodule

// File: tb/tb_jt12_timer_bank.sv
// tb_jt12_timer_bank
//   Directed bench for jt12_timer_bank with NTIM=2, W=10, PRE=4.
//   Edge numbers: e0 is the last edge with rst high; e1 is the first
//   counting edge. With cen=1 the prescaler ticks on every edge that is a
//   multiple of 4. Expected overflow edges below are derived by hand.
module tb_jt12_timer_bank;

  localparam int NTIM = 2;
  localparam int W    = 10;
  localparam int PRE  = 4;

  logic              clk;
  logic              rst;
  logic              cen;
  logic [W-1:0]      v0, v1;
  logic [NTIM*W-1:0] value;
  logic [NTIM*4-1:0] div_log2;
  logic [NTIM-1:0]   set_run, clr_run, enable_irq, clr_flag;
  logic [NTIM-1:0]   running, flag, overflow;
  logic              irq_n;

  int errors;
  int checks;
  int edge_n;
  bit cen_toggle;
  int at;

  assign value = {v1, v0};

  jt12_timer_bank #(
    .NTIM(NTIM),
    .W   (W),
    .PRE (PRE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cen        (cen),
    .value      (value),
    .div_log2   (div_log2),
    .set_run    (set_run),
    .clr_run    (clr_run),
    .enable_irq (enable_irq),
    .clr_flag   (clr_flag),
    .running    (running),
    .flag       (flag),
    .overflow   (overflow),
    .irq_n      (irq_n)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard check
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic step();
    if (cen_toggle) cen = ((edge_n + 1) % 2 == 1);
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic step_to(input int n);
    while (edge_n < n) step();
  endtask

  // Returns the edge after which overflow[idx] is first seen high, or -1.
  task automatic wait_ovf(input int idx, input int limit, output int at_edge);
    at_edge = -1;
    for (int i = 0; i < limit; i++) begin
      step();
      if (overflow[idx]) begin
        at_edge = edge_n;
        break;
      end
    end
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    edge_n     = 0;
    cen_toggle = 1'b0;
    rst        = 1'b1;
    cen        = 1'b1;
    v0         = 10'd1020;
    v1         = 10'd1023;
    div_log2   = 8'h40;
    set_run    = '0;
    clr_run    = '0;
    enable_irq = 2'b01;
    clr_flag   = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_running", running, 0);
    check("rst_flag", flag, 0);
    check("rst_overflow", overflow, 0);
    check("rst_irq_n", irq_n, 1);
    rst = 1'b0;

    // set_run and clr_run together on idle T0: clr wins
    set_run = 2'b01; clr_run = 2'b01;
    step();                                  // e1
    set_run = '0; clr_run = '0;
    check("setclr_idle_running", running, 0);

    // Start T0 at e2 with value 1020: ticks e4,e8,e12, overflow at e16
    set_run = 2'b01;
    step();                                  // e2
    set_run = '0;
    check("t0_start_running", running, 1);
    check("t0_start_no_ovf", overflow, 0);
    wait_ovf(0, 40, at);
    check("t0_first_ovf_edge", at, 16);
    check("t0_flag_set", flag, 1);
    check("t0_irq_low", irq_n, 0);
    step();                                  // e17
    check("t0_ovf_one_cycle", overflow, 0);

    // clr_flag on the same edge as the next overflow (e32): set wins
    step_to(31);
    check("t0_no_early_ovf", overflow, 0);
    clr_flag = 2'b01;
    step();                                  // e32
    clr_flag = '0;
    check("t0_second_ovf", overflow, 1);
    check("t0_flag_set_wins", flag, 1);
    clr_flag = 2'b01;
    step();                                  // e33
    clr_flag = '0;
    check("t0_flag_cleared", flag, 0);
    check("t0_irq_released", irq_n, 1);

    // set_run while running at cnt=1022 (between e40 and e44): no reload
    step_to(40);
    set_run = 2'b01;
    step();                                  // e41
    set_run = '0;
    check("t0_still_running", running, 1);
    wait_ovf(0, 40, at);
    check("t0_no_reload_ovf_edge", at, 48);

    // Drop enable_irq[0]: flag stays; start T1 (value 1023, d=4) at e49
    enable_irq = 2'b00;
    set_run    = 2'b10;
    step();                                  // e49
    set_run    = '0;
    check("en_clear_keeps_flag", flag, 1);
    check("t1_start_running", running, 3);
    clr_flag = 2'b01;
    step();                                  // e50
    clr_flag = '0;
    check("flag_clear_again", flag, 0);

    // T1 ticks on the 16th ptick after start: e112, then every 64 clk
    wait_ovf(1, 100, at);
    check("t1_first_ovf_edge", at, 112);
    check("t1_no_flag", flag, 0);
    check("t1_irq_high", irq_n, 1);
    check("t0_ovf_without_irq", overflow, 3);
    wait_ovf(1, 100, at);
    check("t1_second_ovf_edge", at, 176);

    // Stop T1; change T0 value mid-period: current period stays 16
    v0      = 10'd1000;
    clr_run = 2'b10;
    step();                                  // e177
    clr_run = '0;
    check("t1_stopped", running, 1);
    wait_ovf(0, 40, at);
    check("t0_period_unchanged", at, 192);

    // Reload at e192 used 1000: next period 24 ticks = 96 clk
    v0 = 10'd1020;
    wait_ovf(0, 120, at);
    check("t0_period_24_ticks", at, 288);

    // cen at 50%: prescaler ticks e295,e303,... period doubles to 32 clk
    cen_toggle = 1'b1;
    enable_irq = 2'b01;
    wait_ovf(0, 60, at);
    check("t0_cen_half_first", at, 319);
    check("t0_cen_flag", flag, 1);
    wait_ovf(0, 60, at);
    check("t0_cen_half_period", at, 351);
    check("pre_rst_irq_low", irq_n, 0);

    // Asynchronous reset mid-cycle while overflow is high
    #2 rst = 1'b1;
    #1;
    check("async_rst_running", running, 0);
    check("async_rst_flag", flag, 0);
    check("async_rst_overflow", overflow, 0);
    check("async_rst_irq_n", irq_n, 1);
    #2 rst = 1'b0;

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
